leaf_stream_port_bank: RTL and testbench
========================================

// Module: leaf_stream_port_bank
// PURPOSE
//  Parametrised user-side port bank between HLS ap_vld/ap_ack streams and a leaf_interface.
//  Replaces the fixed 7-in/7-out pass-through wrapper.
//  Adds per-port elastic FIFOs in both directions, a synchronous flush and optional word counters.
//  Sits in the clk_user domain; the packed buses connect directly to the leaf_interface user-side pins.
// PARAMETERS
//  PAYLOAD_BITS    32  data width per port
//  NUM_IN_PORTS     7  user->leaf streams (1..16)
//  NUM_OUT_PORTS    7  leaf->user streams (1..16)
//  FIFO_ADDR_BITS   2  per-port FIFO depth = 2**FIFO_ADDR_BITS (1..6)
// PORTS
//  clk_user            in   1                          user clock; all logic on rising edge
//  reset               in   1                          async, active-high
//  flush               in   1                          sync; empties every FIFO
//  in_data             in   NUM_IN_PORTS*PAYLOAD_BITS  user stream data; port i in bits [i*PAYLOAD_BITS +: PAYLOAD_BITS]
//  in_vld              in   NUM_IN_PORTS               user stream valid
//  in_ack              out  NUM_IN_PORTS               ready to user (= not full)
//  din_leaf_user2interface   out  NUM_IN_PORTS*PAYLOAD_BITS  FIFO head to leaf
//  vld_user2interface        out  NUM_IN_PORTS               FIFO non-empty
//  ack_interface2user        in   NUM_IN_PORTS               leaf accepts head
//  dout_leaf_interface2user  in   NUM_OUT_PORTS*PAYLOAD_BITS data from leaf
//  vld_interface2user        in   NUM_OUT_PORTS              leaf data valid
//  ack_user2interface        out  NUM_OUT_PORTS              ready to leaf (= not full)
//  out_data            out  NUM_OUT_PORTS*PAYLOAD_BITS  FIFO head to user
//  out_vld             out  NUM_OUT_PORTS              FIFO non-empty
//  out_ack             in   NUM_OUT_PORTS              user accepts head
//  stat_in_words       out  NUM_IN_PORTS*32            words accepted per input port
//  stat_out_words      out  NUM_OUT_PORTS*32           words delivered per output port
// BEHAVIOUR
//  - One independent FIFO per port, identical in both directions.
//    Upstream side: (vld, ack=!full); downstream side: (vld=!empty, data=head, ack).
//  - Transfer occurs on a cycle where vld and ack are both high.
//    Push writes the tail; pop advances the head. Head is first-word-fall-through.
//  - ack outputs are registered-state functions (!full) and never depend on upstream vld.
//    No combinational path from any input to any output.
//  - Latency: a word pushed at edge N is visible on the downstream vld/data after edge N (one cycle).
//    Sustained throughput: 1 word/cycle/port.
//  - count is FIFO_ADDR_BITS+1 wide; full = (count == 2**FIFO_ADDR_BITS); empty = (count == 0).
//  - Pointers wrap modulo depth.
//  - Simultaneous push and pop when non-empty and non-full: count is unchanged and both pointers advance.
//  - Push is impossible when full (ack low). Pop is impossible when empty (vld low); a downstream ack while empty is ignored.
//  - Downstream data is don't-care while vld is low; the bench must not check it then.
//  - flush: all pointers and counts go to 0 at the next edge; a push or pop in the same cycle is discarded.
//    Stat counters are not cleared by flush.
//  - reset (async assert, release synchronised by the integrator):
//    - all counts and pointers are 0;
//    - in_ack and ack_user2interface are all 1s;
//    - vld_user2interface and out_vld are 0;
//    - stat counters are 0.
//  - Reset asserted mid-transfer drops all buffered words; no partial state survives.
// CONFIGURATION
//  PORT_STATS_EN defined:
//   - stat_in_words[i] increments on each in_vld&in_ack transfer of port i.
//   - stat_out_words[j] increments on each out_vld&out_ack transfer of port j.
//   - Counters are 32-bit and wrap 0xFFFFFFFF -> 0.
//  PORT_STATS_EN undefined:
//   - no counter registers are built; stat_* outputs are tied to 0.
//   - The port list is unchanged.
// TESTING
//  1. Reset: assert reset with no stimulus -> in_ack/ack_user2interface all 1s; vld_user2interface/out_vld all 0; stat_* 0.
//  2. Fill/drain, depth 4, in port 2:
//     - push 0x11,0x22,0x33,0x44 with ack_interface2user=0 -> in_ack[2]=0 after the 4th push.
//     - Raise ack -> 0x11..0x44 emerge in order on consecutive cycles, then vld goes low.
//  3. Streaming: in_vld and ack_interface2user held high for 100 cycles, incrementing data
//     -> 100 words out in order with no bubble after the first cycle; count stays at 1.
//  4. Full-boundary simultaneity: with FIFO full, pop and present a new word
//     -> pop completes, push is refused that cycle (ack was 0), accepted next cycle.
//  5. Flush: out port 0 holding 3 words, flush pulsed alongside vld_interface2user=1
//     -> out_vld[0]=0 next cycle and the concurrent word is discarded.
//  6. PORT_STATS_EN build: preload a counter to 0xFFFFFFFE via force, do 3 transfers -> reads 0x00000001.
//     Non-stats build: stat_* stay 0 throughout.

Source files
------------

// File: rtl/leaf_stream_port_bank_if.sv
// User-side stream bus of leaf_stream_port_bank: user<->bank and bank<->leaf_interface handshakes.
// The bank takes the slave view; the surrounding user logic / leaf pins take the master view.
interface leaf_stream_port_bank_if #(
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_IN_PORTS  = 7,
  parameter int NUM_OUT_PORTS = 7
);
  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  in_data;
  logic [NUM_IN_PORTS-1:0]               in_vld;
  logic [NUM_IN_PORTS-1:0]               in_ack;
  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  din_leaf_user2interface;
  logic [NUM_IN_PORTS-1:0]               vld_user2interface;
  logic [NUM_IN_PORTS-1:0]               ack_interface2user;
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] dout_leaf_interface2user;
  logic [NUM_OUT_PORTS-1:0]              vld_interface2user;
  logic [NUM_OUT_PORTS-1:0]              ack_user2interface;
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] out_data;
  logic [NUM_OUT_PORTS-1:0]              out_vld;
  logic [NUM_OUT_PORTS-1:0]              out_ack;
  logic [NUM_IN_PORTS*32-1:0]            stat_in_words;
  logic [NUM_OUT_PORTS*32-1:0]           stat_out_words;

  modport slave (
    input  in_data, in_vld, ack_interface2user,
    input  dout_leaf_interface2user, vld_interface2user, out_ack,
    output in_ack, din_leaf_user2interface, vld_user2interface,
    output ack_user2interface, out_data, out_vld,
    output stat_in_words, stat_out_words
  );

  modport master (
    output in_data, in_vld, ack_interface2user,
    output dout_leaf_interface2user, vld_interface2user, out_ack,
    input  in_ack, din_leaf_user2interface, vld_user2interface,
    input  ack_user2interface, out_data, out_vld,
    input  stat_in_words, stat_out_words
  );
endinterface

// File: rtl/leaf_stream_port_bank.sv
// Per-port elastic FIFO bank between HLS ap_vld/ap_ack streams and the leaf_interface user pins.
// Optional per-port word counters are built only when PORT_STATS_EN is defined.
module leaf_stream_fifo #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_vld,
  output logic             wr_ack,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_vld,
  input  logic             rd_ack
);
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS+1)'(DEPTH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr_reg;
  logic [ADDR_BITS-1:0] rd_ptr_reg;
  logic [ADDR_BITS:0]   count_reg;
  logic [ADDR_BITS:0]   count_next;
  logic                 push;
  logic                 pop;

  // Handshake outputs depend only on the registered count, never on the peer's vld/ack.
  assign wr_ack  = (count_reg != FULL_COUNT);
  assign rd_vld  = (count_reg != '0);
  assign rd_data = mem[rd_ptr_reg];
  assign push    = wr_vld & wr_ack;
  assign pop     = rd_ack & rd_vld;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_reg] <= wr_data;
  end
endmodule

module leaf_stream_port_bank #(
  parameter int PAYLOAD_BITS   = 32,
  parameter int NUM_IN_PORTS   = 7,
  parameter int NUM_OUT_PORTS  = 7,
  parameter int FIFO_ADDR_BITS = 2
) (
  input logic                    clk_user,
  input logic                    reset,
  input logic                    flush,
  leaf_stream_port_bank_if.slave bus
);
  genvar gi;

  generate
    for (gi = 0; gi < NUM_IN_PORTS; gi++) begin : g_in_port
      leaf_stream_fifo #(
        .WIDTH    (PAYLOAD_BITS),
        .ADDR_BITS(FIFO_ADDR_BITS)
      ) u_fifo (
        .clk    (clk_user),
        .rst    (reset),
        .flush  (flush),
        .wr_data(bus.in_data[gi*PAYLOAD_BITS +: PAYLOAD_BITS]),
        .wr_vld (bus.in_vld[gi]),
        .wr_ack (bus.in_ack[gi]),
        .rd_data(bus.din_leaf_user2interface[gi*PAYLOAD_BITS +: PAYLOAD_BITS]),
        .rd_vld (bus.vld_user2interface[gi]),
        .rd_ack (bus.ack_interface2user[gi])
      );
`ifdef PORT_STATS_EN
      logic [31:0] stat_reg;
      always_ff @(posedge clk_user or posedge reset) begin
        if (reset)
          stat_reg <= '0;
        else if (bus.in_vld[gi] & bus.in_ack[gi])
          stat_reg <= stat_reg + 32'd1;
      end
      assign bus.stat_in_words[gi*32 +: 32] = stat_reg;
`else
      assign bus.stat_in_words[gi*32 +: 32] = 32'd0;
`endif
    end

    for (gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_out_port
      leaf_stream_fifo #(
        .WIDTH    (PAYLOAD_BITS),
        .ADDR_BITS(FIFO_ADDR_BITS)
      ) u_fifo (
        .clk    (clk_user),
        .rst    (reset),
        .flush  (flush),
        .wr_data(bus.dout_leaf_interface2user[gi*PAYLOAD_BITS +: PAYLOAD_BITS]),
        .wr_vld (bus.vld_interface2user[gi]),
        .wr_ack (bus.ack_user2interface[gi]),
        .rd_data(bus.out_data[gi*PAYLOAD_BITS +: PAYLOAD_BITS]),
        .rd_vld (bus.out_vld[gi]),
        .rd_ack (bus.out_ack[gi])
      );
`ifdef PORT_STATS_EN
      // Counts delivered words: the handshake on the user-facing read side.
      logic [31:0] stat_reg;
      always_ff @(posedge clk_user or posedge reset) begin
        if (reset)
          stat_reg <= '0;
        else if (bus.out_vld[gi] & bus.out_ack[gi])
          stat_reg <= stat_reg + 32'd1;
      end
      assign bus.stat_out_words[gi*32 +: 32] = stat_reg;
`else
      assign bus.stat_out_words[gi*32 +: 32] = 32'd0;
`endif
    end
  endgenerate
endmodule

// File: tb/tb_leaf_stream_port_bank.sv
// Randomised + directed bench for leaf_stream_port_bank against a queue-based reference model.
// Define PORT_STATS_EN for both RTL and bench to exercise the counter build.
module tb_leaf_stream_port_bank;
  localparam int PB    = 32;
  localparam int NI    = 7;
  localparam int NO    = 7;
  localparam int AB    = 2;
  localparam int DEPTH = 1 << AB;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;

  leaf_stream_port_bank_if #(.PAYLOAD_BITS(PB), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO)) bus ();

  leaf_stream_port_bank #(
    .PAYLOAD_BITS  (PB),
    .NUM_IN_PORTS  (NI),
    .NUM_OUT_PORTS (NO),
    .FIFO_ADDR_BITS(AB)
  ) dut (
    .clk_user(clk),
    .reset   (reset),
    .flush   (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] in_q  [NI][$];
  logic [31:0] out_q [NO][$];
  logic [31:0] exp_in_stat  [NI];
  logic [31:0] exp_out_stat [NO];

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear(input bit clr_stats);
    for (int i = 0; i < NI; i++) begin
      in_q[i].delete();
      if (clr_stats) exp_in_stat[i] = '0;
    end
    for (int j = 0; j < NO; j++) begin
      out_q[j].delete();
      if (clr_stats) exp_out_stat[j] = '0;
    end
  endtask

  task automatic check_all();
    logic [NI-1:0] e_in_ack, e_vld_u2i;
    logic [NO-1:0] e_ack_u2i, e_out_vld;
    for (int i = 0; i < NI; i++) begin
      e_in_ack[i]  = (in_q[i].size() < DEPTH);
      e_vld_u2i[i] = (in_q[i].size() > 0);
    end
    for (int j = 0; j < NO; j++) begin
      e_ack_u2i[j] = (out_q[j].size() < DEPTH);
      e_out_vld[j] = (out_q[j].size() > 0);
    end
    check_value("in_ack", 64'(bus.in_ack), 64'(e_in_ack));
    check_value("vld_user2interface", 64'(bus.vld_user2interface), 64'(e_vld_u2i));
    check_value("ack_user2interface", 64'(bus.ack_user2interface), 64'(e_ack_u2i));
    check_value("out_vld", 64'(bus.out_vld), 64'(e_out_vld));
    for (int i = 0; i < NI; i++) begin
      if (in_q[i].size() > 0)
        check_value($sformatf("din_leaf[%0d]", i), 64'(bus.din_leaf_user2interface[i*PB +: PB]), 64'(in_q[i][0]));
      check_value($sformatf("stat_in[%0d]", i), 64'(bus.stat_in_words[i*32 +: 32]), 64'(exp_in_stat[i]));
    end
    for (int j = 0; j < NO; j++) begin
      if (out_q[j].size() > 0)
        check_value($sformatf("out_data[%0d]", j), 64'(bus.out_data[j*PB +: PB]), 64'(out_q[j][0]));
      check_value($sformatf("stat_out[%0d]", j), 64'(bus.stat_out_words[j*32 +: 32]), 64'(exp_out_stat[j]));
    end
  endtask

  // Applies one clock of the reference model using the inputs currently driven, then checks.
  task automatic step();
    bit          push_i [NI];
    bit          pop_i  [NI];
    bit          push_o [NO];
    bit          pop_o  [NO];
    logic [31:0] d_i    [NI];
    logic [31:0] d_o    [NO];
    for (int i = 0; i < NI; i++) begin
      push_i[i] = bus.in_vld[i] && (in_q[i].size() < DEPTH);
      pop_i[i]  = bus.ack_interface2user[i] && (in_q[i].size() > 0);
      d_i[i]    = bus.in_data[i*PB +: PB];
`ifdef PORT_STATS_EN
      if (push_i[i]) exp_in_stat[i] = exp_in_stat[i] + 32'd1;
`endif
    end
    for (int j = 0; j < NO; j++) begin
      push_o[j] = bus.vld_interface2user[j] && (out_q[j].size() < DEPTH);
      pop_o[j]  = bus.out_ack[j] && (out_q[j].size() > 0);
      d_o[j]    = bus.dout_leaf_interface2user[j*PB +: PB];
`ifdef PORT_STATS_EN
      if (pop_o[j]) exp_out_stat[j] = exp_out_stat[j] + 32'd1;
`endif
    end
    if (flush) begin
      model_clear(1'b0);
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (pop_i[i])  void'(in_q[i].pop_front());
        if (push_i[i]) in_q[i].push_back(d_i[i]);
      end
      for (int j = 0; j < NO; j++) begin
        if (pop_o[j])  void'(out_q[j].pop_front());
        if (push_o[j]) out_q[j].push_back(d_o[j]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic drive_idle();
    bus.in_data                  = '0;
    bus.in_vld                   = '0;
    bus.ack_interface2user       = '0;
    bus.dout_leaf_interface2user = '0;
    bus.vld_interface2user       = '0;
    bus.out_ack                  = '0;
    flush                        = 1'b0;
  endtask

  task automatic drive_random(input bit allow_flush);
    for (int i = 0; i < NI; i++) begin
      bus.in_data[i*PB +: PB]  = $urandom;
      bus.in_vld[i]             = ($urandom_range(0, 3) != 0);
      bus.ack_interface2user[i] = ($urandom_range(0, 2) != 0);
    end
    for (int j = 0; j < NO; j++) begin
      bus.dout_leaf_interface2user[j*PB +: PB] = $urandom;
      bus.vld_interface2user[j] = ($urandom_range(0, 3) != 0);
      bus.out_ack[j]            = ($urandom_range(0, 2) != 0);
    end
    flush = allow_flush && ($urandom_range(0, 63) == 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] fill_words [4];
    fill_words = '{32'h11, 32'h22, 32'h33, 32'h44};
    drive_idle();
    model_clear(1'b1);

    // Reset state
    @(negedge clk);
    check_all();
    check_value("reset_in_ack", 64'(bus.in_ack), 64'({NI{1'b1}}));
    check_value("reset_out_vld", 64'(bus.out_vld), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check_all();

    // Fill in port 2 with the leaf side stalled, then drain in order
    for (int k = 0; k < 4; k++) begin
      bus.in_vld[2] = 1'b1;
      bus.in_data[2*PB +: PB] = fill_words[k];
      step();
    end
    check_value("fill_in_ack2", 64'(bus.in_ack[2]), 64'd0);
    bus.in_vld[2] = 1'b0;
    bus.ack_interface2user[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_value("drain_vld2", 64'(bus.vld_user2interface[2]), 64'd1);
      check_value("drain_data2", 64'(bus.din_leaf_user2interface[2*PB +: PB]), 64'(fill_words[k]));
      step();
    end
    check_value("drain_empty2", 64'(bus.vld_user2interface[2]), 64'd0);
    drive_idle();

    // Streaming through in port 0: occupancy stays at one word
    bus.in_vld[0] = 1'b1;
    bus.ack_interface2user[0] = 1'b1;
    for (int k = 0; k < 100; k++) begin
      bus.in_data[0 +: PB] = 32'd1000 + 32'(k);
      step();
      check_value("stream_vld0", 64'(bus.vld_user2interface[0]), 64'd1);
      check_value("stream_data0", 64'(bus.din_leaf_user2interface[0 +: PB]), 64'(32'd1000 + 32'(k)));
    end
    bus.in_vld[0] = 1'b0;
    step();
    check_value("stream_end_vld0", 64'(bus.vld_user2interface[0]), 64'd0);
    drive_idle();

    // Full boundary on in port 3: pop and push together while full
    for (int k = 0; k < DEPTH; k++) begin
      bus.in_vld[3] = 1'b1;
      bus.in_data[3*PB +: PB] = 32'hA0 + 32'(k);
      step();
    end
    check_value("full_in_ack3", 64'(bus.in_ack[3]), 64'd0);
    bus.in_data[3*PB +: PB] = 32'hB0;
    bus.ack_interface2user[3] = 1'b1;
    step();
    check_value("full_pop_head3", 64'(bus.din_leaf_user2interface[3*PB +: PB]), 64'hA1);
    check_value("full_refused_ack3", 64'(bus.in_ack[3]), 64'd1);
    bus.ack_interface2user[3] = 1'b0;
    step();
    check_value("full_accept_ack3", 64'(bus.in_ack[3]), 64'd0);
    bus.in_vld[3] = 1'b0;
    bus.ack_interface2user[3] = 1'b1;
    for (int k = 0; k < 3; k++) step();
    check_value("full_tail3", 64'(bus.din_leaf_user2interface[3*PB +: PB]), 64'hB0);
    step();
    drive_idle();

    // Flush with a concurrent write on out port 0
    for (int k = 0; k < 3; k++) begin
      bus.vld_interface2user[0] = 1'b1;
      bus.dout_leaf_interface2user[0 +: PB] = 32'hC0 + 32'(k);
      step();
    end
    check_value("preflush_out_vld0", 64'(bus.out_vld[0]), 64'd1);
    bus.dout_leaf_interface2user[0 +: PB] = 32'hC3;
    flush = 1'b1;
    step();
    check_value("flush_out_vld0", 64'(bus.out_vld[0]), 64'd0);
    drive_idle();
    step();
    check_value("postflush_out_vld0", 64'(bus.out_vld[0]), 64'd0);

`ifdef PORT_STATS_EN
    // Counter wrap on in port 1
    force dut.g_in_port[1].stat_reg = 32'hFFFF_FFFE;
    #1;
    release dut.g_in_port[1].stat_reg;
    exp_in_stat[1] = 32'hFFFF_FFFE;
    bus.in_vld[1] = 1'b1;
    bus.ack_interface2user[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.in_data[1*PB +: PB] = 32'h500 + 32'(k);
      step();
    end
    check_value("stat_wrap1", 64'(bus.stat_in_words[1*32 +: 32]), 64'h1);
    drive_idle();
    step();
`else
    check_value("stat_in_zero", 64'(bus.stat_in_words[0 +: 64]), 64'd0);
`endif

    // Random traffic with occasional flushes
    for (int c = 0; c < 1500; c++) begin
      drive_random(1'b1);
      step();
    end

    // Asynchronous reset in the middle of a cycle
    drive_random(1'b0);
    #2;
    reset = 1'b1;
    model_clear(1'b1);
    #1;
    check_all();
    check_value("async_rst_ack", 64'(bus.ack_user2interface), 64'({NO{1'b1}}));
    @(negedge clk);
    drive_idle();
    reset = 1'b0;
    check_all();

    for (int c = 0; c < 300; c++) begin
      drive_random(1'b1);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
